// File: rtl/systolic_a_seq_if.sv
// rtl/systolic_a_seq_if.sv - host-side row load handshake for the A-row sequencer
interface systolic_a_seq_if #(
    parameter int BITS_AB = 32,
    parameter int DIM     = 8
);
    localparam int ROW_W = $clog2(DIM);

    logic                      in_valid;
    logic                      in_ready;
    logic [ROW_W-1:0]          in_row;
    logic signed [BITS_AB-1:0] in_data [DIM];

    modport master (output in_valid, in_row, in_data, input in_ready);
    modport slave  (input in_valid, in_row, in_data, output in_ready);
endinterface

// File: rtl/systolic_a_seq.sv
// rtl/systolic_a_seq.sv - A-side row-memory load/drain sequencer
module systolic_a_seq #(
    parameter int BITS_AB = 32,
    parameter int DIM     = 8,
    localparam int ROW_W  = $clog2(DIM),
    localparam int CNT_W  = $clog2(2 * DIM)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    systolic_a_seq_if.slave           ld,
    input  logic                      start,
    output logic                      wr_en,
    output logic [ROW_W-1:0]          wr_row,
    output logic signed [BITS_AB-1:0] wr_data [DIM],
    output logic                      shift_en,
    output logic [DIM-1:0]            loaded,
    output logic                      busy,
    output logic                      done,
    output logic                      start_err
);
    typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept, row_ok, row_wr, in_load, start_ok, start_bad;

    assign in_load     = (state == LOAD) && !clr;
    assign ld.in_ready = in_load;
    assign accept      = ld.in_valid && in_load;
    assign row_wr      = accept && row_ok;

    // A start is only honoured with every row present and no row competing for the cycle
    assign start_ok  = in_load && start && !ld.in_valid && (&loaded);
    assign start_bad = in_load && start && (ld.in_valid || !(&loaded));

    generate
        if ((1 << ROW_W) == DIM) begin : g_pow2
            assign row_ok = 1'b1;
        end else begin : g_npow2
            assign row_ok = ({1'b0, ld.in_row} < (ROW_W + 1)'(DIM));
        end
    endgenerate

    assign shift_en = (state == RUN);
    assign busy     = (state != LOAD);
    assign done     = (state == DONE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (clr) begin
            state_nxt = LOAD;
            cnt_nxt   = '0;
        end else begin
            case (state)
                LOAD: if (start_ok) begin
                    state_nxt = RUN;
                    cnt_nxt   = CNT_W'(2 * DIM - 1);
                end
                RUN: begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state_nxt = DONE;
                end
                DONE:    state_nxt = LOAD;
                default: state_nxt = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            cnt       <= '0;
            wr_en     <= 1'b0;
            wr_row    <= '0;
            start_err <= 1'b0;
            loaded    <= '0;
            for (int k = 0; k < DIM; k++) wr_data[k] <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            wr_en     <= row_wr;
            start_err <= start_bad;
            if (row_wr) begin
                wr_row  <= ld.in_row;
                wr_data <= ld.in_data;
            end
            if (clr || state == DONE) loaded <= '0;
            else if (row_wr)          loaded[ld.in_row] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_systolic_a_seq.sv
// tb/tb_systolic_a_seq.sv - self-checking bench for systolic_a_seq
module tb_systolic_a_seq;
    localparam int BITS_AB = 32;
    localparam int DIM     = 8;
    localparam int ROW_W   = $clog2(DIM);
    localparam int IDLE    = 1000;

    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, start = 1'b0;
    always #5 clk = ~clk;

    systolic_a_seq_if #(.BITS_AB(BITS_AB), .DIM(DIM)) ld ();

    logic                      wr_en;
    logic [ROW_W-1:0]          wr_row;
    logic signed [BITS_AB-1:0] wr_data [DIM];
    logic                      shift_en, busy, done, start_err;
    logic [DIM-1:0]            loaded;

    systolic_a_seq #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .start(start),
        .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data), .shift_en(shift_en),
        .loaded(loaded), .busy(busy), .done(done), .start_err(start_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference: a run is tracked as edges elapsed since the accepted start edge
    int                        since = IDLE;
    bit [DIM-1:0]              m_loaded;
    bit                        m_wr_en, m_start_err;
    int                        m_wr_row;
    logic signed [BITS_AB-1:0] m_wr_data [DIM];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        since = IDLE;
        m_loaded = '0;
        m_wr_en = 1'b0;
        m_start_err = 1'b0;
    endtask

    task automatic model_edge(input bit v, input int row, input bit s, input bit c);
        bit lp, all;
        lp = (since >= 2 * DIM);
        all = &m_loaded;
        m_wr_en = 1'b0;
        m_start_err = 1'b0;
        if (c) begin
            since = IDLE;
            m_loaded = '0;
        end else begin
            if (since == 2 * DIM - 1) m_loaded = '0;
            if (lp) begin
                if (v && row < DIM) begin
                    m_wr_en = 1'b1;
                    m_wr_row = row;
                    m_wr_data = ld.in_data;
                    m_loaded[row] = 1'b1;
                end
                if (s) begin
                    if (!v && all) since = -1;
                    else m_start_err = 1'b1;
                end
            end
            if (since < IDLE) since++;
        end
    endtask

    task automatic compare_model();
        chk("wr_en", wr_en, m_wr_en);
        if (m_wr_en) begin
            chk("wr_row", wr_row, m_wr_row);
            for (int k = 0; k < DIM; k++) chk("wr_data", wr_data[k], m_wr_data[k]);
        end
        chk("shift_en", shift_en, since <= 2 * DIM - 2);
        chk("done", done, since == 2 * DIM - 1);
        chk("busy", busy, since <= 2 * DIM - 1);
        chk("start_err", start_err, m_start_err);
        chk("loaded", loaded, m_loaded);
    endtask

    task automatic step(input bit v, input int row, input bit s, input bit c);
        ld.in_valid = v;
        ld.in_row = row[ROW_W-1:0];
        start = s;
        clr = c;
        #1;
        chk("in_ready", ld.in_ready, (since >= 2 * DIM) && !c);
        @(posedge clk);
        model_edge(v, row, s, c);
        #1;
        compare_model();
    endtask

    task automatic set_data(input int row, input int tag);
        for (int k = 0; k < DIM; k++) ld.in_data[k] = row * 16 + k + tag * 256;
    endtask

    task automatic load_all(input int tag);
        for (int r = 0; r < DIM; r++) begin
            set_data(r, tag);
            step(1, r, 0, 0);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic run_check(input bit abort);
        int sh, first_sh, last_sh, done_at;
        sh = 0; first_sh = -1; last_sh = -1; done_at = -1;
        step(0, 0, 1, 0);
        for (int i = 1; i <= 2 * DIM + 1; i++) begin
            if (shift_en) begin
                sh++;
                if (first_sh < 0) first_sh = i;
                last_sh = i;
            end
            if (done) done_at = i;
            if (abort && sh == 5) begin
                step(0, 0, 0, 1);
                clr = 1'b0;
                #1;
                chk("abort_shift_en", shift_en, 1'b0);
                chk("abort_loaded", loaded, '0);
                chk("abort_in_ready", ld.in_ready, 1'b1);
                for (int j = 0; j < 2 * DIM; j++) begin
                    step(0, 0, 0, 0);
                    if (done) done_at = j;
                end
                chk("abort_no_done", done_at, -1);
                return;
            end
            if (i == 2 * DIM + 1) begin
                chk("post_run_loaded", loaded, '0);
                chk("post_run_in_ready", ld.in_ready, 1'b1);
            end
            step(0, 0, 0, 0);
        end
        chk("shift_cycles", sh, 2 * DIM - 1);
        chk("first_shift", first_sh, 1);
        chk("last_shift", last_sh, 2 * DIM - 1);
        chk("done_cycle", done_at, 2 * DIM);
    endtask

    typedef struct {
        bit       v;
        int       row;
        int       tag;
        bit       s;
        bit       c;
        bit       e_wr;
        int       e_row;
        bit       e_serr;
        bit [7:0] e_loaded;
    } vec_t;

    vec_t tbl [23];

    initial begin
        for (int i = 0; i < 8; i++) tbl[i] = '{1, i, 0, 0, 0, 1, i, 0, 8'((1 << (i + 1)) - 1)};
        tbl[8]  = '{1, 2, 1, 0, 0, 1, 2, 0, 8'hFF};
        tbl[9]  = '{1, 2, 2, 0, 0, 1, 2, 0, 8'hFF};
        tbl[10] = '{1, 3, 3, 1, 0, 1, 3, 1, 8'hFF};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 8'hFF};
        tbl[12] = '{1, 5, 0, 0, 1, 0, 0, 0, 8'h00};
        for (int i = 0; i < 7; i++) tbl[13 + i] = '{1, i, 4, 0, 0, 1, i, 0, 8'((1 << (i + 1)) - 1)};
        tbl[20] = '{0, 0, 0, 1, 0, 0, 0, 1, 8'h7F};
        tbl[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 8'h7F};
        tbl[22] = '{1, 7, 4, 0, 0, 1, 7, 0, 8'hFF};

        ld.in_valid = 1'b0;
        ld.in_row = '0;
        set_data(0, 0);
        model_reset();

        #12;
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_row", wr_row, '0);
        chk("rst_wr_data0", wr_data[0], '0);
        chk("rst_shift_en", shift_en, 1'b0);
        chk("rst_loaded", loaded, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_start_err", start_err, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", ld.in_ready, 1'b1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 23; i++) begin
            set_data(tbl[i].row, tbl[i].tag);
            step(tbl[i].v, tbl[i].row, tbl[i].s, tbl[i].c);
            chk("tbl_wr_en", wr_en, tbl[i].e_wr);
            if (tbl[i].e_wr) chk("tbl_wr_row", wr_row, tbl[i].e_row);
            chk("tbl_start_err", start_err, tbl[i].e_serr);
            chk("tbl_loaded", loaded, tbl[i].e_loaded);
            if (i == 9) chk("tbl_overwrite_data", wr_data[1], 32'(2 * 16 + 1 + 2 * 256));
            if (i == 11) run_check(0);
        end
        run_check(0);

        load_all(5);
        run_check(1);

        for (int n = 0; n < 400; n++) begin
            bit v, s, c;
            int r;
            v = ($urandom % 2) == 0;
            r = $urandom % DIM;
            s = ($urandom % 6) == 0;
            c = ($urandom % 60) == 0;
            for (int k = 0; k < DIM; k++) ld.in_data[k] = $urandom;
            step(v, r, s, c);
        end
        step(0, 0, 0, 0);
        clr = 1'b0;

        load_all(6);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("pre_rst_shift_en", shift_en, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_shift_en", shift_en, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_loaded", loaded, '0);
        chk("async_rst_wr_en", wr_en, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_all(7);
        run_check(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/systolic_a_seq.md
# systolic_a_seq

Sequencer for the systolic array's A-side row memory. It accepts A-matrix rows from the host-facing load path through a valid/ready handshake and issues one-row-per-cycle write strobes to the A row memory. It tracks which of the DIM rows hold data. On a start request with all rows present, it asserts the memory's shift enable for the skewed drain window and signals completion. It sits between the host load interface and the A row-memory instance feeding the PE array.

## Interface
- BITS_AB, 32, signed element width
- DIM, 8, array dimension: rows, and elements per row
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous abort/clear, highest priority
- in_valid  in  1  row offered
- in_ready  out  1  row can be accepted
- in_row  in  $clog2(DIM)  row index of offered row
- in_data  in  BITS_AB x DIM (signed, unpacked)  row elements
- start  in  1  request a drain run, sampled in LOAD only
- wr_en  out  1  write strobe to row memory
- wr_row  out  $clog2(DIM)  row index for write
- wr_data  out  BITS_AB x DIM (signed, unpacked)  row data for write
- shift_en  out  1  shift/drain enable to row memory
- loaded  out  DIM  bitmap of rows written since last clear/run
- busy  out  1  high in RUN or DONE
- done  out  1  one-cycle pulse at end of run
- start_err  out  1  one-cycle pulse when start is rejected

## Operation
- States: LOAD (reset state), RUN, DONE.
- Handshake: in_ready = (state==LOAD) & ~clr, combinational. A row is accepted on any edge where in_valid & in_ready.
- LOAD, row accepted: register wr_en=1, wr_row=in_row, wr_data=in_data, and set loaded[in_row]. Rewriting a loaded row is legal: data is overwritten and the bitmap is unchanged. If DIM is not a power of two, in_row>=DIM completes the handshake, but the row is dropped with no wr_en and no bitmap change.
- LOAD, start accepted: requires start & ~in_valid & (loaded == all ones). Next state is RUN, and the run counter is loaded with 2*DIM-1.
- LOAD, start rejected: start & (in_valid | loaded != all ones). start_err pulses for one cycle and the state stays LOAD. A row offered in the same cycle is still accepted.
- start outside LOAD is ignored and does not pulse start_err.
- RUN: shift_en=1 every cycle and the counter decrements. When the count of 1 is consumed, go to DONE.
- DONE: lasts one cycle. done=1, loaded is cleared to 0, and the next state is LOAD.
- clr from any state: next state is LOAD, loaded=0, and the counter is 0. wr_en, shift_en, done and start_err are all 0 in the following cycle. No done is issued for an aborted run, and a row offered in the clr cycle is not accepted.
- Counter width is $clog2(2*DIM); it never wraps because it is reloaded only on start.

## Timing
- Reset values: state=LOAD, wr_en=0, wr_row=0, wr_data=all 0, shift_en=0, loaded=0, done=0, start_err=0, busy=0. in_ready=1 after reset deasserts, provided clr=0.
- Write latency is 1: a row accepted at edge t drives wr_en/wr_row/wr_data during cycle t+1 for exactly one cycle.
- Back-to-back rows give one wr_en per cycle with no bubbles.
- A start accepted at edge t causes:
  - shift_en high for cycles t+1 through t+2*DIM-1, which is exactly 2*DIM-1 cycles;
  - done high in cycle t+2*DIM;
  - in_ready high again in cycle t+2*DIM+1.
- The last wr_en precedes the first shift_en by at least one cycle, because start is rejected whenever in_valid is high.
- busy is registered from the state: high from t+1 through t+2*DIM.
- start_err is high in the cycle after the rejected start edge.
- Asynchronous rst_n assertion mid-RUN drops shift_en immediately, and all outputs take their reset values.

## Test plan
- Reset, then load rows 0..7 back-to-back with in_data[k]=row*16+k. Expect 8 consecutive wr_en cycles, with wr_row 0..7 and data matching, each one cycle after acceptance. loaded = 8'hFF.
- With loaded=8'hFF, pulse start at edge t. Expect shift_en for exactly 15 cycles (t+1..t+15), done at t+16, loaded=0 at t+17, and in_ready=1 at t+17.
- Load rows 0..6 only, then start. Expect start_err for one cycle, no shift_en, and state unchanged. Then load row 7 and start again, which must succeed.
- Load all rows, then assert start and in_valid (row 3) in the same cycle. Expect the row written, start_err pulsed, and no shift_en. A later start alone must succeed.
- Raise clr on the 5th shift_en cycle. Expect shift_en=0 from the next cycle, no done, loaded=0, and in_ready=1.
- Overwrite row 2 twice before start. Expect two wr_en strobes carrying the second data last, with loaded unchanged.
